// File: rtl/v_mem_init_pkg.sv
// Shared types for v_mem_init: controller states and fill modes.
package v_mem_init_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_CONST = 1'b0,
    MODE_INCR  = 1'b1
  } fill_mode_e;

endpackage

// File: rtl/v_mem_init.sv
// Memory-bank initialiser: writes a constant or incrementing pattern over an address range.
// Define V_MEM_INIT_PATTERN_EN to build the incrementing-pattern data path.
//   state   | meaning
//   ST_IDLE | waiting for i_start
//   ST_BUSY | one write per cycle on the output port
//   ST_DONE | one-cycle done pulse (err set if the request was rejected)
module v_mem_init
  import v_mem_init_pkg::*;
#(
  parameter int  N     = 256,
  parameter int  W     = 32,
  parameter int  BANKS = 1,
  localparam int AW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [AW-1:0]    i_start_addr,
  input  logic [AW-1:0]    i_end_addr,
  input  logic [W-1:0]     i_fill,
  input  logic             i_mode,
  input  logic [BANKS-1:0] i_bank_mask,
  output logic [BANKS-1:0] o_wen_r,
  output logic [AW-1:0]    o_waddr_r,
  output logic [W-1:0]     o_wdata_r,
  output logic             o_busy_r,
  output logic             o_done_r,
  output logic             o_err_r
);

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW-1:0]    end_q, end_d;
  logic [W-1:0]     data_q, data_d;
  logic [BANKS-1:0] mask_q, mask_d;
  logic [BANKS-1:0] wen_q, wen_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             req_bad;

`ifdef V_MEM_INIT_PATTERN_EN
  fill_mode_e       mode_q, mode_d;
`else
  logic             unused_mode;
  assign unused_mode = i_mode;
`endif

  // end >= N is only reachable when N is not a power of two
  assign req_bad = (i_start_addr > i_end_addr) || (int'(i_end_addr) >= N) ||
                   (i_bank_mask == '0);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    end_d   = end_q;
    data_d  = data_q;
    mask_d  = mask_q;
    wen_d   = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef V_MEM_INIT_PATTERN_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          addr_d = i_start_addr;
          end_d  = i_end_addr;
          data_d = i_fill;
          mask_d = i_bank_mask;
`ifdef V_MEM_INIT_PATTERN_EN
          mode_d = fill_mode_e'(i_mode);
`endif
          if (req_bad) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ST_BUSY;
            wen_d   = i_bank_mask;
          end
        end
      end
      ST_BUSY: begin
        // compare before incrementing so end = N-1 never wraps the counter
        if (i_abort) begin
          state_d = ST_IDLE;
        end else if (addr_q == end_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          addr_d = addr_q + AW'(1);
          wen_d  = mask_q;
`ifdef V_MEM_INIT_PATTERN_EN
          if (mode_q == MODE_INCR) data_d = data_q + W'(1);
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      end_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      wen_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef V_MEM_INIT_PATTERN_EN
      mode_q  <= MODE_CONST;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef V_MEM_INIT_PATTERN_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign o_wen_r   = wen_q;
  assign o_waddr_r = addr_q;
  assign o_wdata_r = data_q;
  assign o_busy_r  = busy_q;
  assign o_done_r  = done_q;
  assign o_err_r   = err_q;

endmodule

// File: tb/tb_v_mem_init.sv
// Self-checking bench for v_mem_init: directed corner fills plus randomized fills
// checked against a per-request write-list model.
module tb_v_mem_init;

  localparam int N     = 16;
  localparam int W     = 32;
  localparam int BANKS = 4;
  localparam int AW    = $clog2(N);
`ifdef V_MEM_INIT_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             i_start, i_abort, i_mode;
  logic [AW-1:0]    i_start_addr, i_end_addr;
  logic [W-1:0]     i_fill;
  logic [BANKS-1:0] i_bank_mask;
  logic [BANKS-1:0] o_wen_r;
  logic [AW-1:0]    o_waddr_r;
  logic [W-1:0]     o_wdata_r;
  logic             o_busy_r, o_done_r, o_err_r;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  v_mem_init #(.N(N), .W(W), .BANKS(BANKS)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_start_addr (i_start_addr),
    .i_end_addr   (i_end_addr),
    .i_fill       (i_fill),
    .i_mode       (i_mode),
    .i_bank_mask  (i_bank_mask),
    .o_wen_r      (o_wen_r),
    .o_waddr_r    (o_waddr_r),
    .o_wdata_r    (o_wdata_r),
    .o_busy_r     (o_busy_r),
    .o_done_r     (o_done_r),
    .o_err_r      (o_err_r)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic scramble();
    i_start_addr = AW'($urandom);
    i_end_addr   = AW'($urandom);
    i_fill       = $urandom;
    i_mode       = 1'($urandom);
    i_bank_mask  = BANKS'($urandom);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wen"},   32'(o_wen_r), 0);
    chk({tag, "_waddr"}, 32'(o_waddr_r), 0);
    chk({tag, "_wdata"}, o_wdata_r, 0);
    chk({tag, "_busy"},  32'(o_busy_r), 0);
    chk({tag, "_done"},  32'(o_done_r), 0);
    chk({tag, "_err"},   32'(o_err_r), 0);
  endtask

  // Issues one request from a negedge and follows it until the DUT goes idle.
  // abort_at > 0 raises i_abort so that it is sampled right after write number abort_at.
  task automatic run_fill(input int s, input int e, input logic [31:0] f, input bit m,
                          input logic [3:0] msk, input int abort_at, input bit hold,
                          input bit abort_with_start);
    bit          exp_err, do_abort;
    int          n_full, n_exp, exp_done_k, exp_idle_k;
    int          nw, ndone, done_k, idle_k;
    logic        err_seen;
    logic [31:0] exp_d;

    exp_err  = (s > e) || (e >= N) || (msk == 4'b0);
    n_full   = exp_err ? 0 : e - s + 1;
    do_abort = (abort_at > 0) && (abort_at <= n_full);
    n_exp    = do_abort ? abort_at : n_full;
    exp_done_k = do_abort ? 0 : n_exp + 1;
    exp_idle_k = do_abort ? abort_at + 1 : n_exp + 2;

    i_start_addr = AW'(s);
    i_end_addr   = AW'(e);
    i_fill       = f;
    i_mode       = m;
    i_bank_mask  = msk;
    i_start      = 1'b1;
    i_abort      = abort_with_start;
    @(posedge clk);

    nw = 0; ndone = 0; done_k = 0; idle_k = 0; err_seen = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (o_wen_r != '0) begin
        exp_d = (PAT && m) ? f + 32'(nw) : f;
        chk("waddr", 32'(o_waddr_r), 32'(s + nw));
        chk("wdata", o_wdata_r, exp_d);
        chk("wen",   32'(o_wen_r), 32'(msk));
        nw++;
      end
      if (o_done_r) begin
        ndone++;
        done_k   = k;
        err_seen = o_err_r;
      end
      if (!hold || o_done_r) i_start = 1'b0;
      if (!hold) scramble();
      i_abort = do_abort && (k == abort_at);
      if (!o_busy_r) begin
        idle_k = k;
        break;
      end
    end
    i_start = 1'b0;
    i_abort = 1'b0;

    chk("nwrites", 32'(nw), 32'(n_exp));
    chk("ndone",   32'(ndone), do_abort ? 0 : 1);
    chk("done_cyc", 32'(done_k), 32'(exp_done_k));
    chk("err",     32'(err_seen), (!do_abort && exp_err) ? 1 : 0);
    chk("idle_cyc", 32'(idle_k), 32'(exp_idle_k));
  endtask

  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    i_abort = 1'b0;
    scramble();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // full range constant fill, request right after reset release
    run_fill(0, 15, 32'h0000_00A5, 1'b0, 4'b0001, 0, 1'b0, 1'b0);
    // pattern fill wrapping through zero
    run_fill(4, 7, 32'hFFFF_FFFE, 1'b1, 4'b1111, 0, 1'b0, 1'b0);
    // reversed range and empty mask are rejected
    run_fill(9, 3, 32'h1234_5678, 1'b0, 4'b0011, 0, 1'b0, 1'b0);
    run_fill(2, 5, 32'h1234_5678, 1'b0, 4'b0000, 0, 1'b0, 1'b0);
    // abort takes effect in the third busy cycle, then a new request is accepted
    run_fill(0, 10, 32'hCAFE_0000, 1'b1, 4'b1000, 2, 1'b0, 1'b0);
    run_fill(3, 3, 32'h0000_0042, 1'b0, 4'b0110, 0, 1'b0, 1'b0);
    // two-bank mask, start held high, start+abort together in idle
    run_fill(5, 12, 32'h0BAD_F00D, 1'b1, 4'b0101, 0, 1'b0, 1'b0);
    run_fill(1, 6, 32'h0000_0077, 1'b1, 4'b1010, 0, 1'b1, 1'b0);
    run_fill(10, 15, 32'h0000_0011, 1'b0, 4'b0101, 0, 1'b0, 1'b1);
    // abort coinciding with the final write suppresses done
    run_fill(6, 8, 32'h0000_0099, 1'b0, 4'b0011, 3, 1'b0, 1'b0);

    // reset in the middle of a fill
    i_start_addr = 4'd0; i_end_addr = 4'd15; i_fill = 32'hDEAD_BEEF;
    i_mode = 1'b1; i_bank_mask = 4'b0101; i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    repeat (2) @(negedge clk);
    chk("midfill_busy", 32'(o_busy_r), 1);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst = 1'b0;
    run_fill(2, 9, 32'h5555_0000, 1'b1, 4'b1100, 0, 1'b0, 1'b0);

    for (int t = 0; t < 25; t++) begin
      int s, e, ab;
      s  = $urandom_range(0, N - 1);
      e  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, N - 1)
                                       : $urandom_range(s, N - 1);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      run_fill(s, e, $urandom, 1'($urandom), 4'($urandom), ab,
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/v_mem_init.md
V_MEM_INIT -- requirements
Module: v_mem_init

Interface
REQ-001 SHALL have parameter N, default 256: words per bank (N >= 2); AW = $clog2(N).
REQ-002 SHALL have parameter W, default 32: word width in bits.
REQ-003 SHALL have parameter BANKS, default 1: banks written in parallel (BANKS >= 1).
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have i_start  in  1: request a fill; sampled only in IDLE.
REQ-006 SHALL have i_abort  in  1: terminate an active fill.
REQ-007 SHALL have i_start_addr  in  AW, and i_end_addr  in  AW: inclusive fill range.
REQ-008 SHALL have i_fill  in  W: fill value or pattern seed.
REQ-009 SHALL have i_mode  in  1: 0 = constant fill, 1 = incrementing pattern.
REQ-010 SHALL have i_bank_mask  in  BANKS: banks to write.
REQ-011 SHALL have o_wen_r  out  BANKS; o_waddr_r  out  AW; o_wdata_r  out  W: registered write port shared by all banks.
REQ-012 SHALL have o_busy_r  out  1; o_done_r  out  1 (one-cycle pulse); o_err_r  out  1 (valid with o_done_r).

Function
REQ-013 SHALL implement states IDLE, BUSY, DONE: IDLE->BUSY on valid i_start; BUSY->DONE after the final write; BUSY->IDLE on i_abort; DONE->IDLE unconditionally.
REQ-014 SHALL latch start, end, fill, mode and bank mask when i_start is accepted, and SHALL ignore input changes until the fill ends.
REQ-015 SHALL place the first write (o_waddr_r = start) one cycle after i_start, then issue one write per cycle at consecutive addresses.
REQ-016 SHALL issue exactly end - start + 1 writes; o_wen_r = latched mask during writes, else zero.
REQ-017 SHALL detect the final address by comparing against the latched end before incrementing, so that end = N-1 never wraps the counter.
REQ-018 SHALL drive o_wdata_r = fill in constant mode; in pattern mode, fill + (addr - start), truncated modulo 2^W.
REQ-019 SHALL treat start > end, end >= N, or an all-zero mask as an error: no writes, DONE one cycle after i_start, with o_err_r = 1.
REQ-020 SHALL assert o_done_r for exactly the DONE cycle, one cycle after the final write.
REQ-021 SHALL hold o_busy_r high in BUSY and DONE.
REQ-022 SHALL ignore i_start while busy; when i_start and i_abort arrive in the same IDLE cycle, SHALL accept the start.
REQ-023 SHALL, on i_abort in BUSY, write no further words from the next cycle, enter IDLE, and raise no o_done_r.

Reset
REQ-024 SHALL, when rst is high, enter IDLE and zero o_wen_r, o_waddr_r, o_wdata_r, o_busy_r, o_done_r and o_err_r on the next edge, including mid-fill.
REQ-025 SHALL allow i_start in the first cycle after rst deasserts.

Configuration
REQ-026 SHALL, with V_MEM_INIT_PATTERN_EN defined, support i_mode = 1 as in REQ-018.
REQ-027 SHALL, without V_MEM_INIT_PATTERN_EN, ignore i_mode, treat every fill as constant, and omit the pattern adder.

Structure
REQ-028 SHALL place the FSM state enum and the fill-mode enum in shared package v_mem_init_pkg.
REQ-029 SHALL be a single module with no sub-modules; address counter and data generator are inline.

Verification
REQ-030 SHALL cover: N=16, start=0, end=15, constant 0xA5 -> 16 writes, addr 0..15, data 0xA5, done pulse in the cycle after addr 15, err=0.
REQ-031 SHALL cover: pattern mode, start=4, end=7, fill=0xFFFFFFFE, W=32 -> data FFFFFFFE, FFFFFFFF, 0, 1.
REQ-032 SHALL cover: start=9, end=3 -> zero writes, done=1 and err=1 one cycle after start.
REQ-033 SHALL cover: i_abort in the third BUSY cycle -> exactly 2 writes, no done, busy low next cycle, and a new i_start accepted.
REQ-034 SHALL cover: BANKS=4, mask=4'b0101 -> o_wen_r = 0101 on every write; rst asserted mid-fill -> all outputs zero next cycle.
REQ-035 SHALL cover: i_start held high through the fill -> exactly one fill, no restart until IDLE.
